// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson sequence decoder slice.
package johnson_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/johnson_code_classify.sv
// Combinational classifier: checks a Q/Qbar sample for Johnson legality and
// decodes it to its position in the 2N-long sequence.
module johnson_code_classify #(
    parameter int N  = 4,
    parameter int IW = $clog2(2*N)
) (
    input  logic [N-1:0]  q_in,
    input  logic [N-1:0]  qbar_in,
    output logic          legal,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  nq;
    logic [N-1:0]  q_inc;
    logic [N-1:0]  nq_inc;
    logic          code_ok;
    logic [IW-1:0] pop_q;
    logic [IW-1:0] pop_nq;

    assign nq     = ~q_in;
    assign q_inc  = q_in + {{(N-1){1'b0}}, 1'b1};
    assign nq_inc = nq + {{(N-1){1'b0}}, 1'b1};

    // First half is a run of ones from the LSB; second half is the inverse of such a run.
    assign code_ok = q_in[N-1] ? ((nq & nq_inc) == '0) : ((q_in & q_inc) == '0);
    assign legal   = code_ok && (qbar_in == nq);

    always_comb begin
        pop_q  = '0;
        pop_nq = '0;
        for (int i = 0; i < N; i++) begin
            pop_q  = pop_q  + IW'(q_in[i]);
            pop_nq = pop_nq + IW'(nq[i]);
        end
    end

    assign idx = q_in[N-1] ? (IW'(N) + pop_nq) : pop_q;

endmodule

// File: rtl/johnson_seq_decoder.sv
// Johnson counter receive-side monitor: decodes Q/Qbar samples, tracks the
// sequence, locks after a run of correct successors and counts errors.
module johnson_seq_decoder
    import johnson_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int LOCK_LEN = 3,
    localparam int IW       = $clog2(2*N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 q_valid,
    input  logic [N-1:0]         q_in,
    input  logic [N-1:0]         qbar_in,
    output logic [IW-1:0]        idx,
    output logic                 idx_valid,
    output logic                 illegal,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int RW = $clog2(LOCK_LEN + 1);

    state_t               state_reg, state_next;
    logic [RW-1:0]        run_reg, run_next;
    logic [IW-1:0]        idx_reg, idx_next;
    logic                 idx_valid_reg, idx_valid_next;
    logic                 illegal_reg, illegal_next;
    logic                 seq_err_reg, seq_err_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;
    logic                 err_inc;

    logic                 c_legal;
    logic [IW-1:0]        c_idx;
    logic [IW-1:0]        exp_idx;
    logic                 match;

    johnson_code_classify #(
        .N  (N),
        .IW (IW)
    ) u_classify (
        .q_in    (q_in),
        .qbar_in (qbar_in),
        .legal   (c_legal),
        .idx     (c_idx)
    );

    // idx_reg always holds the last legal index, so it doubles as prev_idx.
    assign exp_idx = (idx_reg == IW'(2*N-1)) ? '0 : idx_reg + IW'(1);
    assign match   = (c_idx == exp_idx);

    always_comb begin
        state_next     = state_reg;
        run_next       = run_reg;
        idx_next       = idx_reg;
        idx_valid_next = 1'b0;
        illegal_next   = 1'b0;
        seq_err_next   = 1'b0;
        err_inc        = 1'b0;
        if (q_valid) begin
            if (c_legal) begin
                idx_next       = c_idx;
                idx_valid_next = 1'b1;
            end
            case (state_reg)
                SEARCH: begin
                    if (c_legal) begin
                        state_next = CHECK;
                        run_next   = '0;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
                CHECK: begin
                    if (!c_legal) begin
                        state_next   = SEARCH;
                        run_next     = '0;
                        illegal_next = 1'b1;
                    end else if (match) begin
                        if (32'(run_reg) + 1 == LOCK_LEN) begin
                            state_next = LOCKED;
                            run_next   = '0;
                        end else begin
                            run_next = run_reg + RW'(1);
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                LOCKED: begin
                    if (!c_legal) begin
                        state_next   = SEARCH;
                        illegal_next = 1'b1;
                        err_inc      = 1'b1;
                    end else if (!match) begin
                        state_next   = CHECK;
                        run_next     = '0;
                        seq_err_next = 1'b1;
                        err_inc      = 1'b1;
                    end
                end
                default: begin
                    state_next = SEARCH;
                    run_next   = '0;
                end
            endcase
        end
    end

    assign err_cnt_next = (err_inc && (err_cnt_reg != '1)) ? err_cnt_reg + ERR_CNT_W'(1)
                                                           : err_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= SEARCH;
            run_reg       <= '0;
            idx_reg       <= '0;
            idx_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            seq_err_reg   <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= run_next;
            idx_reg       <= idx_next;
            idx_valid_reg <= idx_valid_next;
            illegal_reg   <= illegal_next;
            seq_err_reg   <= seq_err_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign idx       = idx_reg;
    assign idx_valid = idx_valid_reg;
    assign illegal   = illegal_reg;
    assign seq_err   = seq_err_reg;
    assign locked    = (state_reg == LOCKED);
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_johnson_seq_decoder.sv
// Randomised bench for johnson_seq_decoder against a table-driven sequence model.
module tb_johnson_seq_decoder;

    localparam int N        = 4;
    localparam int LOCK_LEN = 3;
    localparam int IW       = $clog2(2*N);
    localparam int SEQ      = 2*N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          q_valid = 1'b0;
    logic [N-1:0]  q_in = '0;
    logic [N-1:0]  qbar_in = '1;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          illegal;
    logic          seq_err;
    logic          locked;
    logic [7:0]    err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    johnson_seq_decoder #(.N(N), .LOCK_LEN(LOCK_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_valid   (q_valid),
        .q_in      (q_in),
        .qbar_in   (qbar_in),
        .idx       (idx),
        .idx_valid (idx_valid),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // k-th code of the sequence: a growing run of ones, then ones shifted out upward.
    function automatic logic [N-1:0] code(input int k);
        int m;
        logic [N-1:0] full;
        m    = k % SEQ;
        full = '1;
        if (m < N) code = N'((1 << m) - 1);
        else       code = full << (m - N);
    endfunction

    function automatic void lookup(input logic [N-1:0] q, input logic [N-1:0] qb,
                                   output bit ok, output int k);
        ok = 1'b0;
        k  = 0;
        for (int i = 0; i < SEQ; i++)
            if (code(i) == q) begin
                ok = (qb == ~q);
                k  = i;
            end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: "seeded" means a reference index exists, "streak" counts
    // correct successors since the last reseed; locked once the streak is long enough.
    bit m_seeded = 0;
    int m_streak = 0;
    int m_prev   = 0;
    int m_errs   = 0;
    int e_idx = 0, e_iv = 0, e_ill = 0, e_se = 0, e_lock = 0;

    always @(posedge clk or negedge rst) begin
        bit ok, was_locked;
        int k;
        if (!rst) begin
            m_seeded = 0; m_streak = 0; m_prev = 0; m_errs = 0;
            e_idx = 0; e_iv = 0; e_ill = 0; e_se = 0; e_lock = 0;
        end else begin
            e_iv = 0; e_ill = 0; e_se = 0;
            if (q_valid) begin
                lookup(q_in, qbar_in, ok, k);
                was_locked = m_seeded && (m_streak >= LOCK_LEN);
                if (!ok) begin
                    e_ill = 1;
                    if (was_locked && m_errs < 255) m_errs++;
                    m_seeded = 0;
                    m_streak = 0;
                end else begin
                    e_iv = 1;
                    if (m_seeded && k == (m_prev + 1) % SEQ) begin
                        if (m_streak < LOCK_LEN) m_streak++;
                    end else begin
                        if (was_locked) begin
                            e_se = 1;
                            if (m_errs < 255) m_errs++;
                        end
                        m_seeded = 1;
                        m_streak = 0;
                    end
                    m_prev = k;
                    e_idx  = k;
                end
                e_lock = (m_seeded && m_streak >= LOCK_LEN) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("idx", int'(idx), e_idx);
        chk("idx_valid", int'(idx_valid), e_iv);
        chk("illegal", int'(illegal), e_ill);
        chk("seq_err", int'(seq_err), e_se);
        chk("locked", int'(locked), e_lock);
        chk("err_cnt", int'(err_cnt), m_errs);
    end

    task automatic samp(input logic v, input logic [N-1:0] q, input logic [N-1:0] qb);
        @(negedge clk);
        q_valid = v;
        q_in    = q;
        qbar_in = qb;
        @(posedge clk);
        #1;
        $display("sample v=%0b q=%b qbar=%b -> idx=%0d iv=%0b ill=%0b se=%0b lock=%0b err=%0d",
                 v, q, qb, idx, idx_valid, illegal, seq_err, locked, err_cnt);
    endtask

    task automatic feed(input int k);
        samp(1'b1, code(k), ~code(k));
    endtask

    task automatic gap();
        logic [N-1:0] junk;
        junk = N'($urandom);
        samp(1'b0, junk, N'($urandom));
    endtask

    initial begin
        int cur;
        // 1: reset, then one full pass of the sequence
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idx", int'(idx), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < SEQ; k++) begin
            feed(k);
            chk("t1_idx", int'(idx), k);
            if (k == 2) chk("t1_not_locked", int'(locked), 0);
            if (k == 3) chk("t1_locked", int'(locked), 1);
        end
        // 2: sequence error while locked, then relock
        for (int k = 0; k < 4; k++) feed(k);
        feed(2);
        chk("t2_seq_err", int'(seq_err), 1);
        chk("t2_err_cnt", int'(err_cnt), 1);
        chk("t2_unlocked", int'(locked), 0);
        for (int k = 3; k < 7; k++) feed(k);
        chk("t2_relocked", int'(locked), 1);
        // 3: illegal code, then Q/Qbar mismatch
        samp(1'b1, 4'b0101, 4'b1010);
        chk("t3_illegal_code", int'(illegal), 1);
        chk("t3_err_cnt", int'(err_cnt), 2);
        chk("t3_idx_hold", int'(idx), 6);
        chk("t3_search", int'(locked), 0);
        samp(1'b1, 4'b0011, 4'b1101);
        chk("t3_illegal_qbar", int'(illegal), 1);
        chk("t3_err_cnt_search", int'(err_cnt), 2);
        chk("t3_idx_hold2", int'(idx), 6);
        // 4: wrap with gaps
        feed(7); feed(0); feed(1); feed(2);
        for (int k = 3; k <= 8; k++) begin
            repeat ($urandom_range(0, 2)) gap();
            feed(k);
        end
        chk("t4_wrap_idx", int'(idx), 0);
        chk("t4_no_seq_err", int'(seq_err), 0);
        chk("t4_locked", int'(locked), 1);
        gap();
        chk("t4_gap_locked", int'(locked), 1);
        chk("t4_gap_no_pulse", int'(idx_valid), 0);
        // random traffic
        cur = 0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [N-1:0] rq;
            r = $urandom_range(0, 9);
            if (r == 0) gap();
            else if (r <= 6) begin cur = (cur + 1) % SEQ; feed(cur); end
            else if (r == 7) begin cur = $urandom_range(0, SEQ-1); feed(cur); end
            else if (r == 8) feed(cur);
            else begin
                rq = N'($urandom);
                samp(1'b1, rq, ($urandom_range(0, 2) == 0) ? N'($urandom) : ~rq);
            end
        end
        // 5: saturate the error counter
        for (int k = 0; k < 4; k++) begin cur = (cur + 1) % SEQ; feed(cur); end
        for (int e = 0; e < 300; e++) begin
            feed(cur);
            for (int k = 0; k < LOCK_LEN; k++) begin cur = (cur + 1) % SEQ; feed(cur); end
        end
        chk("t5_saturated", int'(err_cnt), 255);
        feed(cur);
        chk("t5_still_255", int'(err_cnt), 255);
        chk("t5_seq_err", int'(seq_err), 1);
        feed(cur + 1); feed(cur + 2);
        // asynchronous reset away from the clock edge
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_idx", int'(idx), 0);
        chk("t5_rst_iv", int'(idx_valid), 0);
        chk("t5_rst_locked", int'(locked), 0);
        chk("t5_rst_err_cnt", int'(err_cnt), 0);
        chk("t5_rst_seq_err", int'(seq_err), 0);
        chk("t5_rst_illegal", int'(illegal), 0);
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
